noc_credit_repeater: RTL and testbench
======================================

Name: noc_credit_repeater

Overview:
- Credit-based link repeater placed on a router-to-router link, directly downstream of a router output port (data/dest/is_tail/send/credit interface) and upstream of the neighbouring router input.
- Buffers flits and returns credits to the upstream router, so the upstream router sees a short, local credit loop.
- Forwards flits downstream under its own credit counter, which lets long inter-router wires be broken into credit-correct segments.

Parameters:
- FLIT_WIDTH, 128, flit payload width.
- DEST_WIDTH, 4, destination field width ({tid, tdest}).
- BUFFER_DEPTH, 4, local FIFO entries; the upstream router must be configured with exactly this many credits.
- DOWNSTREAM_CREDITS, 4, initial credit count, equal to the downstream input buffer depth.
- CNT_WIDTH, $clog2(max(BUFFER_DEPTH,DOWNSTREAM_CREDITS)+1), width of the occupancy and credit counters.

Ports:
- clk_noc  in  1  NoC clock; everything is on this single clock.
- rst_noc_sync  in  1  synchronous, active-high reset.
- data_in  in  FLIT_WIDTH  upstream flit payload.
- dest_in  in  DEST_WIDTH  upstream flit destination.
- is_tail_in  in  1  upstream tail marker.
- send_in  in  1  upstream flit valid, one flit per high cycle.
- credit_out  out  1  credit-return pulse to upstream.
- data_out  out  FLIT_WIDTH  downstream flit payload.
- dest_out  out  DEST_WIDTH  downstream flit destination.
- is_tail_out  out  1  downstream tail marker.
- send_out  out  1  downstream flit valid.
- credit_in  in  1  credit-return pulse from downstream.
- occupancy  out  CNT_WIDTH  current FIFO entry count.
- credits_avail  out  CNT_WIDTH  current downstream credit count.
- overflow_err  out  1  sticky: a flit arrived while the FIFO was full and nothing was popped that cycle.
- credit_err  out  1  sticky: credit_in arrived while the counter was already at DOWNSTREAM_CREDITS.

Behaviour:
- Reset (rst_noc_sync=1 at a clk_noc edge):
  - send_out, credit_out, data_out, dest_out, is_tail_out = 0.
  - FIFO empty, occupancy = 0, credits_avail = DOWNSTREAM_CREDITS.
  - overflow_err and credit_err cleared.
  - Reset mid-packet flushes the FIFO silently; no credits are returned for flushed flits, because both link neighbours are reset together.
- Every output is registered; there is no combinational path from any input to any output.
- Pop condition: (FIFO non-empty OR send_in) AND credits_avail>0.
  - On a pop, the oldest flit is loaded into the output register and send_out=1 for exactly one cycle.
  - Otherwise send_out=0. data_out, dest_out and is_tail_out hold their last values and are don't-care when send_out=0.
- Bypass: if the FIFO is empty, send_in=1 and credits_avail>0, the incoming flit goes straight to the output register.
  - Latency is 1 cycle: send_in high in cycle c gives send_out high in cycle c+1.
  - The buffered path has the same 1-cycle minimum from the cycle a flit reaches the FIFO head with credit available.
- credit_out is a registered pulse asserted in the same cycle as send_out: one credit per forwarded flit.
- Credit counter update:
  - pop → −1; credit_in → +1; both in the same cycle → unchanged.
  - credit_in at the maximum saturates the counter and sets credit_err.
  - Pops never occur at 0 credits, so the counter cannot underflow.
- FIFO update: push on send_in unless the flit is bypassed; pop as defined above.
  - Simultaneous push and pop when full is legal; occupancy is unchanged and no error is flagged.
  - A push when full with no pop drops the flit and sets overflow_err; occupancy stays at BUFFER_DEPTH.
- Ordering is strict FIFO. is_tail is carried through unchanged; there are no packet semantics and no wormhole locking.
- Throughput is 1 flit/cycle sustained when the downstream returns credits with round-trip ≤ DOWNSTREAM_CREDITS cycles.

Decomposition:
- Shared package noc_link_pkg holds:
  - the default width localparams (FLIT_WIDTH 128, DEST_WIDTH 4);
  - a packed link status struct {overflow_err, credit_err};
  - a clog2-max helper function used for CNT_WIDTH.
- One sub-module, noc_flit_fifo:
  - parameterised width and depth;
  - push/pop/full/empty/count interface, with count as CNT_WIDTH;
  - storage as a register array, no memory inference required.
- The repeater top holds the bypass mux, the credit counter, the output register and the error flags.

Test Plan:
- Reset → all outputs 0, credits_avail=4, occupancy=0; 10 flits sent during reset → none forwarded and no credit_out.
- Single flit (data 0xA5…, dest 4'h3, tail=1) with credits 4 → send_out 1 cycle later with identical fields, credit_out in the same cycle, credits_avail=3.
- 10 back-to-back flits, credit_in tied so it pulses 2 cycles after each send_out → 10 send_out pulses in order with no gap after the first, occupancy ≤1, final credits_avail=4.
- credit_in held 0 and 6 flits sent → 4 forwarded, then 2 buffered (occupancy=2, credits_avail=0); then 2 credit_in pulses → the remaining 2 are forwarded in order.
- FIFO full (4) and credits 0, send_in=1 → flit dropped, overflow_err=1, occupancy=4. Same cycle with one credit available → push and pop both happen, overflow_err unchanged.
- credit_in at credits_avail=4 → counter stays 4, credit_err=1. Simultaneous pop and credit_in at credits 2 → credits stay 2.

Source files
------------

// File: rtl/noc_link_pkg.sv
// Shared types, default widths and helpers for router-to-router link blocks.
package noc_link_pkg;

   localparam int NOC_FLIT_WIDTH = 128;
   localparam int NOC_DEST_WIDTH = 4;

   // Sticky link error flags, reported together so one checker can watch them.
   typedef struct packed {
      logic overflow_err;
      logic credit_err;
   } link_status_t;

   // Width needed to count from 0 up to and including max(a, b).
   function automatic int clog2_max(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Register-array flit FIFO. A push is accepted while full only if a pop happens in the same cycle.
module noc_flit_fifo
   import noc_link_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int CNT_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic                 pop,
   output logic [WIDTH-1:0]     rd_data,
   output logic                 full,
   output logic                 empty,
   output logic [CNT_WIDTH-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr;
   logic [CNT_WIDTH-1:0] count_q;
   logic                 do_push;
   logic                 do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign count   = count_q;
   assign rd_data = mem[rd_ptr];

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_WIDTH'(1);
            2'b01:   count_q <= count_q - CNT_WIDTH'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/noc_credit_repeater.sv
// Credit-based link repeater: buffers flits, returns one upstream credit per forwarded flit,
// and forwards downstream under its own credit counter. All outputs are registered.
module noc_credit_repeater
   import noc_link_pkg::*;
#(
   parameter int FLIT_WIDTH         = NOC_FLIT_WIDTH,
   parameter int DEST_WIDTH         = NOC_DEST_WIDTH,
   parameter int BUFFER_DEPTH       = 4,
   parameter int DOWNSTREAM_CREDITS = 4,
   parameter int CNT_WIDTH          = clog2_max(BUFFER_DEPTH, DOWNSTREAM_CREDITS)
) (
   input  logic                  clk_noc,
   input  logic                  rst_noc_sync,
   input  logic [FLIT_WIDTH-1:0] data_in,
   input  logic [DEST_WIDTH-1:0] dest_in,
   input  logic                  is_tail_in,
   input  logic                  send_in,
   output logic                  credit_out,
   output logic [FLIT_WIDTH-1:0] data_out,
   output logic [DEST_WIDTH-1:0] dest_out,
   output logic                  is_tail_out,
   output logic                  send_out,
   input  logic                  credit_in,
   output logic [CNT_WIDTH-1:0]  occupancy,
   output logic [CNT_WIDTH-1:0]  credits_avail,
   output logic                  overflow_err,
   output logic                  credit_err
);

   // Link handshake: there is no ready. send is a one-cycle valid that the receiver must
   // accept because the sender only sends while holding a credit; each credit pulse
   // returns exactly one buffer slot to the sender.

   localparam int ENTRY_W = 1 + DEST_WIDTH + FLIT_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CRED_MAX = CNT_WIDTH'(DOWNSTREAM_CREDITS);

   logic [ENTRY_W-1:0]   in_entry;
   logic [ENTRY_W-1:0]   head_entry;
   logic [ENTRY_W-1:0]   out_entry;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CNT_WIDTH-1:0] fifo_count;
   logic                 credit_ok;
   logic                 pop;
   logic                 bypass;
   logic                 fifo_pop;
   logic                 fifo_push;
   logic                 drop;
   logic [CNT_WIDTH-1:0] credits_q;
   link_status_t         status_q;

   assign in_entry  = {is_tail_in, dest_in, data_in};
   assign credit_ok = (credits_q != '0);

   assign pop       = (!fifo_empty || send_in) && credit_ok;
   assign bypass    = fifo_empty && send_in && credit_ok;
   assign fifo_pop  = pop && !fifo_empty;
   assign fifo_push = send_in && !bypass;
   // A full FIFO always has a head to pop, so a flit is lost only when credits are exhausted.
   assign drop      = send_in && fifo_full && !fifo_pop;

   assign out_entry = bypass ? in_entry : head_entry;

   noc_flit_fifo #(
      .WIDTH    (ENTRY_W),
      .DEPTH    (BUFFER_DEPTH),
      .CNT_WIDTH(CNT_WIDTH)
   ) u_fifo (
      .clk    (clk_noc),
      .rst    (rst_noc_sync),
      .push   (fifo_push),
      .wr_data(in_entry),
      .pop    (fifo_pop),
      .rd_data(head_entry),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   always_ff @(posedge clk_noc) begin
      if (rst_noc_sync) begin
         send_out    <= 1'b0;
         credit_out  <= 1'b0;
         data_out    <= '0;
         dest_out    <= '0;
         is_tail_out <= 1'b0;
      end else begin
         send_out   <= pop;
         credit_out <= pop;
         if (pop) begin
            {is_tail_out, dest_out, data_out} <= out_entry;
         end
      end
   end

   always_ff @(posedge clk_noc) begin
      if (rst_noc_sync) begin
         credits_q <= CRED_MAX;
         status_q  <= '0;
      end else begin
         case ({pop, credit_in})
            2'b10:   credits_q <= credits_q - CNT_WIDTH'(1);
            2'b01:   credits_q <= (credits_q == CRED_MAX) ? credits_q : credits_q + CNT_WIDTH'(1);
            default: credits_q <= credits_q;
         endcase
         if (credit_in && (credits_q == CRED_MAX)) begin
            status_q.credit_err <= 1'b1;
         end
         if (drop) begin
            status_q.overflow_err <= 1'b1;
         end
      end
   end

   assign occupancy     = fifo_count;
   assign credits_avail = credits_q;
   assign overflow_err  = status_q.overflow_err;
   assign credit_err    = status_q.credit_err;

endmodule

// File: tb/tb_noc_credit_repeater.sv
// Directed bench for noc_credit_repeater: expected flits are queued at issue time and a
// negedge monitor pops and compares every forwarded flit.
module tb_noc_credit_repeater;

   localparam int FW = 128;
   localparam int DW = 4;
   localparam int CW = 3;
   localparam int EW = 1 + DW + FW;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic [FW-1:0] data_in = '0;
   logic [DW-1:0] dest_in = '0;
   logic          is_tail_in = 1'b0;
   logic          send_in = 1'b0;
   logic          credit_out;
   logic [FW-1:0] data_out;
   logic [DW-1:0] dest_out;
   logic          is_tail_out;
   logic          send_out;
   logic          credit_in;
   logic [CW-1:0] occupancy;
   logic [CW-1:0] credits_avail;
   logic          overflow_err;
   logic          credit_err;

   // downstream credit model: manual pulses, or an automatic return 2 cycles after send_out
   logic       credit_manual = 1'b0;
   logic       auto_en = 1'b0;
   logic [1:0] sh = '0;
   always @(posedge clk) sh <= {sh[0], send_out};
   assign credit_in = credit_manual | (auto_en & sh[1]);

   noc_credit_repeater dut (
      .clk_noc      (clk),
      .rst_noc_sync (rst),
      .data_in      (data_in),
      .dest_in      (dest_in),
      .is_tail_in   (is_tail_in),
      .send_in      (send_in),
      .credit_out   (credit_out),
      .data_out     (data_out),
      .dest_out     (dest_out),
      .is_tail_out  (is_tail_out),
      .send_out     (send_out),
      .credit_in    (credit_in),
      .occupancy    (occupancy),
      .credits_avail(credits_avail),
      .overflow_err (overflow_err),
      .credit_err   (credit_err)
   );

   // scoreboard
   logic [EW-1:0] exp_q[$];
   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic gap_track = 1'b0;
   logic occ_track = 1'b0;
   logic prev_valid = 1'b0;
   int   prev_cyc = 0;
   int   gaps = 0;
   int   n_pops = 0;
   int   max_occ = 0;

   // monitor
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (credit_out || send_out) check("credit_pulse", 136'(credit_out), 136'(send_out));
      if (send_out) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_flit actual=%0h required=none", {is_tail_out, dest_out, data_out});
         end else begin
            e = exp_q.pop_front();
            check("flit_fields", 136'({is_tail_out, dest_out, data_out}), 136'(e));
         end
         if (gap_track) begin
            if (prev_valid && (cyc != prev_cyc + 1)) gaps++;
            prev_valid = 1'b1;
            prev_cyc   = cyc;
            n_pops++;
         end
      end
      if (occ_track && (int'(occupancy) > max_occ)) max_occ = int'(occupancy);
   end

   // driver tasks
   function automatic logic [FW-1:0] mk_data(input int i);
      logic [31:0] w;
      w = 32'hC0DE_0000 + 32'(i);
      return {4{w}};
   endfunction

   task automatic send_flit(input logic [FW-1:0] d, input logic [DW-1:0] dst, input logic t,
                            input logic cr, input logic expect_fwd);
      data_in       = d;
      dest_in       = dst;
      is_tail_in    = t;
      send_in       = 1'b1;
      credit_manual = cr;
      if (expect_fwd) exp_q.push_back({t, dst, d});
      @(posedge clk);
      #1;
      send_in       = 1'b0;
      credit_manual = 1'b0;
   endtask

   task automatic pulse_credit();
      credit_manual = 1'b1;
      @(posedge clk);
      #1;
      credit_manual = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      check(name, 136'(exp_q.size()), 136'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // reset with traffic: nothing may be forwarded
      idle(2);
      for (int i = 0; i < 10; i++) send_flit(mk_data(i), 4'(i), 1'(i), 1'b0, 1'b0);
      idle(1);
      @(negedge clk);
      check("rst_send_out", 136'(send_out), 136'(0));
      check("rst_credit_out", 136'(credit_out), 136'(0));
      check("rst_data_out", 136'(data_out), 136'(0));
      check("rst_dest_out", 136'(dest_out), 136'(0));
      check("rst_tail_out", 136'(is_tail_out), 136'(0));
      check("rst_occupancy", 136'(occupancy), 136'(0));
      check("rst_credits", 136'(credits_avail), 136'(4));
      check("rst_overflow", 136'(overflow_err), 136'(0));
      check("rst_credit_err", 136'(credit_err), 136'(0));
      rst = 1'b0;
      idle(3);
      @(negedge clk);
      check("post_rst_idle", 136'(send_out), 136'(0));

      // single flit, bypass latency 1
      send_flit({16{8'hA5}}, 4'h3, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      check("single_send_out", 136'(send_out), 136'(1));
      check("single_credit_out", 136'(credit_out), 136'(1));
      check("single_credits", 136'(credits_avail), 136'(3));
      pulse_credit();
      idle(1);
      @(negedge clk);
      check("single_credits_back", 136'(credits_avail), 136'(4));

      // 10 back-to-back flits with 2-cycle credit return
      auto_en   = 1'b1;
      gap_track = 1'b1;
      occ_track = 1'b1;
      for (int i = 0; i < 10; i++) send_flit(mk_data(100 + i), 4'(i + 2), (i == 9), 1'b0, 1'b1);
      wait_drain("b2b_drain", 40);
      idle(6);
      @(negedge clk);
      check("b2b_gaps", 136'(gaps), 136'(0));
      check("b2b_pops", 136'(n_pops), 136'(10));
      check("b2b_max_occ_le1", 136'(max_occ <= 1), 136'(1));
      check("b2b_credits", 136'(credits_avail), 136'(4));
      auto_en   = 1'b0;
      gap_track = 1'b0;
      occ_track = 1'b0;

      // credit starvation: 4 forwarded, 2 buffered
      for (int i = 0; i < 6; i++) send_flit(mk_data(200 + i), 4'(9 - i), (i == 5), 1'b0, 1'b1);
      idle(2);
      @(negedge clk);
      check("starve_occupancy", 136'(occupancy), 136'(2));
      check("starve_credits", 136'(credits_avail), 136'(0));
      check("starve_pending", 136'(exp_q.size()), 136'(2));
      pulse_credit();
      pulse_credit();
      wait_drain("starve_drain", 10);
      idle(1);
      @(negedge clk);
      check("starve_credits_after", 136'(credits_avail), 136'(0));
      check("starve_occ_after", 136'(occupancy), 136'(0));

      // full FIFO: push+pop with one credit, then drop with none
      for (int i = 0; i < 4; i++) send_flit(mk_data(300 + i), 4'hA, 1'b0, 1'b0, 1'b1);
      idle(1);
      @(negedge clk);
      check("full_occupancy", 136'(occupancy), 136'(4));
      check("full_overflow_clear", 136'(overflow_err), 136'(0));
      pulse_credit();
      send_flit(mk_data(304), 4'hB, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      check("pushpop_occupancy", 136'(occupancy), 136'(4));
      check("pushpop_overflow", 136'(overflow_err), 136'(0));
      check("pushpop_credits", 136'(credits_avail), 136'(0));
      send_flit(mk_data(305), 4'hC, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("drop_overflow", 136'(overflow_err), 136'(1));
      check("drop_occupancy", 136'(occupancy), 136'(4));
      for (int i = 0; i < 4; i++) pulse_credit();
      wait_drain("full_drain", 10);
      idle(1);
      @(negedge clk);
      check("full_occ_after", 136'(occupancy), 136'(0));

      // reset again clears sticky flags and restores credits
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1);
      @(negedge clk);
      check("rst2_overflow", 136'(overflow_err), 136'(0));
      check("rst2_credits", 136'(credits_avail), 136'(4));

      // credit at maximum saturates and flags
      pulse_credit();
      @(negedge clk);
      check("cred_sat_value", 136'(credits_avail), 136'(4));
      check("cred_sat_err", 136'(credit_err), 136'(1));

      // pop and credit_in together at credits 2
      send_flit(mk_data(400), 4'h1, 1'b0, 1'b0, 1'b1);
      send_flit(mk_data(401), 4'h2, 1'b0, 1'b0, 1'b1);
      send_flit(mk_data(402), 4'h4, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      check("pop_and_credit", 136'(credits_avail), 136'(2));
      wait_drain("final_drain", 10);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
